// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drive_pkg
//  Description : Shared codes for the car drive scheduler: controller state
//                codes, motor moving codes, mode codes, scheduler FSM
//                encoding and a mode-mapping helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package drive_pkg;

    // Controller state codes
    localparam logic [1:0] ST_WAITING = 2'b00;
    localparam logic [1:0] ST_MOVING  = 2'b01;
    localparam logic [1:0] ST_TURNING = 2'b10;
    localparam logic [1:0] ST_COOLING = 2'b11;

    // Motor moving codes
    localparam logic [3:0] MV_STOP  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    // Mode codes; MODE_NONE means no controller owns the motors
    localparam logic [1:0] MODE_MAN  = 2'b00;
    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_SEMI = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    // Scheduler FSM encoding
    typedef logic [1:0] fsm_t;
    localparam fsm_t FSM_OFF      = 2'd0;
    localparam fsm_t FSM_RUN      = 2'd1;
    localparam fsm_t FSM_HANDOVER = 2'd2;

    // The reserved request code falls back to manual when powering up
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return (m == MODE_NONE) ? MODE_MAN : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drive_mode_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running divider producing a one-cycle tick every
//                TICK_DIV clock cycles (on the cycle the counter wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 2_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);

    localparam int             c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/drive_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : drive_mode_scheduler
//  Description : Owns power, global_state and the shared state/moving_state
//                registers. Routes the active mode controller's next pair,
//                runs a timed STOP handover on mode changes and toggles
//                power on a long press of power_btn.
//  Revision    : 1.0 - initial release
// ============================================================================
module drive_mode_scheduler
    import drive_pkg::*;
#(
    parameter int TICK_DIV         = 2_000_000,
    parameter int POWER_HOLD_TICKS = 50,
    parameter int HANDOVER_TICKS   = 25
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic [1:0] mode_sel,
    input  logic [1:0] man_next_state,
    input  logic [3:0] man_next_move,
    input  logic [1:0] auto_next_state,
    input  logic [3:0] auto_next_move,
    input  logic [1:0] semi_next_state,
    input  logic [3:0] semi_next_move,
    output logic       power,
    output logic [1:0] global_state,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       handover_busy
);

    localparam int                  c_hold_w   = $clog2(POWER_HOLD_TICKS + 1);
    localparam int                  c_hcnt_w   = $clog2(HANDOVER_TICKS + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(POWER_HOLD_TICKS);
    localparam logic [c_hcnt_w-1:0] c_hcnt_max = c_hcnt_w'(HANDOVER_TICKS);

    logic                w_tick;
    logic [c_hold_w-1:0] r_hold;
    logic                r_armed;
    logic                w_long_press;

    fsm_t                r_fsm;
    fsm_t                w_fsm_nxt;

    logic                r_power,  w_power_nxt;
    logic [1:0]          r_global, w_global_nxt;
    logic [1:0]          r_state,  w_state_nxt;
    logic [3:0]          r_move,   w_move_nxt;
    logic                r_busy,   w_busy_nxt;
    logic [1:0]          r_target, w_target_nxt;
    logic [c_hcnt_w-1:0] r_hcnt,   w_hcnt_nxt;

    logic                w_mode_valid;
    logic [1:0]          w_route_state;
    logic [3:0]          w_route_move;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick    (w_tick)
    );

    assign w_long_press = (r_hold == c_hold_max);
    assign w_mode_valid = (mode_sel != MODE_NONE);

    // Hold counter: one toggle per press, re-armed only by releasing the button
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_hold  <= '0;
            r_armed <= 1'b1;
        end else if (!power_btn) begin
            r_hold  <= '0;
            r_armed <= 1'b1;
        end else if (w_long_press) begin
            r_hold  <= '0;
            r_armed <= 1'b0;
        end else if (w_tick && r_armed && (r_hold != c_hold_max)) begin
            r_hold  <= r_hold + 1'b1;
        end
    end

    // Select the next pair of the controller that currently owns the motors
    always_comb begin
        w_route_state = ST_WAITING;
        w_route_move  = MV_STOP;
        case (r_global)
            MODE_MAN: begin
                w_route_state = man_next_state;
                w_route_move  = man_next_move;
            end
            MODE_AUTO: begin
                w_route_state = auto_next_state;
                w_route_move  = auto_next_move;
            end
            MODE_SEMI: begin
                w_route_state = semi_next_state;
                w_route_move  = semi_next_move;
            end
            default: begin
                w_route_state = ST_WAITING;
                w_route_move  = MV_STOP;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_fsm <= FSM_OFF;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state logic; long press outranks every other event
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            FSM_OFF: begin
                if (w_long_press) begin
                    w_fsm_nxt = FSM_RUN;
                end
            end
            FSM_RUN: begin
                if (w_long_press) begin
                    w_fsm_nxt = FSM_OFF;
                end else if (w_mode_valid && (mode_sel != r_global)) begin
                    w_fsm_nxt = FSM_HANDOVER;
                end
            end
            FSM_HANDOVER: begin
                if (w_long_press) begin
                    w_fsm_nxt = FSM_OFF;
                end else if (w_mode_valid && (mode_sel != r_target)) begin
                    w_fsm_nxt = FSM_HANDOVER;
                end else if (r_hcnt == c_hcnt_max) begin
                    w_fsm_nxt = FSM_RUN;
                end
            end
            default: begin
                w_fsm_nxt = FSM_OFF;
            end
        endcase
    end

    // Next values of the registered outputs and handover bookkeeping
    always_comb begin
        w_power_nxt  = r_power;
        w_global_nxt = r_global;
        w_state_nxt  = r_state;
        w_move_nxt   = r_move;
        w_busy_nxt   = r_busy;
        w_target_nxt = r_target;
        w_hcnt_nxt   = r_hcnt;
        case (r_fsm)
            FSM_RUN: begin
                if (w_long_press) begin
                    w_power_nxt  = 1'b0;
                    w_global_nxt = MODE_NONE;
                    w_state_nxt  = ST_WAITING;
                    w_move_nxt   = MV_STOP;
                    w_busy_nxt   = 1'b0;
                end else if (w_mode_valid && (mode_sel != r_global)) begin
                    w_target_nxt = mode_sel;
                    w_global_nxt = MODE_NONE;
                    w_state_nxt  = ST_WAITING;
                    w_move_nxt   = MV_STOP;
                    w_hcnt_nxt   = '0;
                    w_busy_nxt   = 1'b1;
                end else begin
                    w_state_nxt  = w_route_state;
                    w_move_nxt   = w_route_move;
                end
            end
            FSM_HANDOVER: begin
                w_state_nxt = ST_WAITING;
                w_move_nxt  = MV_STOP;
                if (w_long_press) begin
                    w_power_nxt  = 1'b0;
                    w_global_nxt = MODE_NONE;
                    w_busy_nxt   = 1'b0;
                end else if (w_mode_valid && (mode_sel != r_target)) begin
                    // A newer request restarts the full STOP interval
                    w_target_nxt = mode_sel;
                    w_hcnt_nxt   = '0;
                end else if (r_hcnt == c_hcnt_max) begin
                    w_global_nxt = r_target;
                    w_busy_nxt   = 1'b0;
                end else if (w_tick) begin
                    w_hcnt_nxt   = r_hcnt + 1'b1;
                end
            end
            default: begin
                // OFF: outputs parked at reset values until a long press
                w_power_nxt  = 1'b0;
                w_global_nxt = MODE_NONE;
                w_state_nxt  = ST_WAITING;
                w_move_nxt   = MV_STOP;
                w_busy_nxt   = 1'b0;
                w_hcnt_nxt   = '0;
                if (w_long_press) begin
                    w_power_nxt  = 1'b1;
                    w_global_nxt = map_mode(mode_sel);
                end
            end
        endcase
    end

    // Output and handover registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_power  <= 1'b0;
            r_global <= MODE_NONE;
            r_state  <= ST_WAITING;
            r_move   <= MV_STOP;
            r_busy   <= 1'b0;
            r_target <= MODE_MAN;
            r_hcnt   <= '0;
        end else begin
            r_power  <= w_power_nxt;
            r_global <= w_global_nxt;
            r_state  <= w_state_nxt;
            r_move   <= w_move_nxt;
            r_busy   <= w_busy_nxt;
            r_target <= w_target_nxt;
            r_hcnt   <= w_hcnt_nxt;
        end
    end

    assign power         = r_power;
    assign global_state  = r_global;
    assign state         = r_state;
    assign moving_state  = r_move;
    assign handover_busy = r_busy;

endmodule
`default_nettype wire
